// File: rtl/hop_pkg.sv
// Shared definitions for the horizontal output controller: FSM states,
// beats per group and the rom_phase beat boundaries.
package hop_pkg;

    localparam int         HOP_BEATS    = 16;
    localparam logic [3:0] PHASE1_START = 4'd4;
    localparam logic [3:0] PHASE2_START = 4'd12;
    localparam logic [1:0] PHASE_IDLE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } hop_state_e;

endpackage

// File: rtl/hop_beat_cnt.sv
// Beat counter for one horizontal output group plus the rom_phase decode.
// The counter wraps at the last beat so back-to-back groups restart at 0.
module hop_beat_cnt
    import hop_pkg::*;
#(
    parameter int BEATS = HOP_BEATS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    output logic [3:0] beat,
    output logic [1:0] rom_phase,
    output logic       last_beat
);

    localparam logic [3:0] LAST = 4'(BEATS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= 4'd0;
        end else if (clear) begin
            beat <= 4'd0;
        end else if (enable) begin
            beat <= (beat == LAST) ? 4'd0 : beat + 4'd1;
        end
    end

    always_comb begin
        rom_phase = PHASE_IDLE;
        if (enable) begin
            if (beat < PHASE1_START) begin
                rom_phase = 2'd0;
            end else if (beat < PHASE2_START) begin
                rom_phase = 2'd1;
            end else begin
                rom_phase = 2'd2;
            end
        end
    end

    assign last_beat = enable && (beat == LAST);

endmodule

// File: rtl/horizontal_out_ctrl.sv
// Sequences 16-beat output groups to the horizontal router: group counting,
// write-address generation and the IDLE/WAIT/BURST/DONE control FSM.
module horizontal_out_ctrl
    import hop_pkg::*;
#(
    parameter int GRP_WIDTH = 10,
    parameter int BEATS     = HOP_BEATS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [GRP_WIDTH-1:0] grp_num,
    input  logic                 mul_valid,
    output logic                 horizontal_en,
    output logic [3:0]           beat,
    output logic [1:0]           rom_phase,
    output logic [GRP_WIDTH-1:0] rom_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [GRP_WIDTH-1:0] ONE_GRP = GRP_WIDTH'(1);

    hop_state_e           state;
    hop_state_e           state_nx;
    logic [GRP_WIDTH-1:0] remaining;
    logic                 last_beat;

    hop_beat_cnt #(
        .BEATS (BEATS)
    ) u_beat_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (horizontal_en),
        .clear     (~horizontal_en),
        .beat      (beat),
        .rom_phase (rom_phase),
        .last_beat (last_beat)
    );

    // start is a single-cycle request honoured only in IDLE; mul_valid is a
    // level that gates entry into a burst but never stalls one in progress.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (grp_num != '0) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (mul_valid) begin
                    state_nx = ST_BURST;
                end
            end
            ST_BURST: begin
                if (last_beat) begin
                    if (remaining <= ONE_GRP) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = mul_valid ? ST_BURST : ST_WAIT;
                    end
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so the router sees
    // clean, glitch-free levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            horizontal_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nx;
            horizontal_en <= (state_nx == ST_BURST);
            busy          <= (state_nx == ST_WAIT) || (state_nx == ST_BURST);
            done          <= (state_nx == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            rom_addr  <= '0;
            err       <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                remaining <= grp_num;
                rom_addr  <= '0;
                err       <= 1'b0;
            end
            if (state == ST_BURST) begin
                if (!mul_valid && !last_beat) begin
                    err <= 1'b1;
                end
                if (last_beat) begin
                    if (remaining > ONE_GRP) begin
                        remaining <= remaining - ONE_GRP;
                        rom_addr  <= rom_addr + ONE_GRP;
                    end else begin
                        remaining <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_horizontal_out_ctrl.sv
// Bench for horizontal_out_ctrl: scenario tasks plus a scoreboard that
// checks every enabled beat against {rom_addr, beat, rom_phase} expectations.
module tb_horizontal_out_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] grp_num = '0;
    logic         mul_valid = 1'b0;
    logic         horizontal_en;
    logic [3:0]   beat;
    logic [1:0]   rom_phase;
    logic [W-1:0] rom_addr;
    logic         busy;
    logic         done;
    logic         err;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [W+5:0] exp_q[$];
    logic [W+5:0] exp_v;

    horizontal_out_ctrl #(
        .GRP_WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .grp_num       (grp_num),
        .mul_valid     (mul_valid),
        .horizontal_en (horizontal_en),
        .beat          (beat),
        .rom_phase     (rom_phase),
        .rom_addr      (rom_addr),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] exp_phase(input int b);
        if (b < 4) return 2'd0;
        if (b < 12) return 2'd1;
        return 2'd2;
    endfunction

    // Scoreboard: every enabled beat pops one expected record.
    always @(negedge clk) begin
        if (rst_n && horizontal_en === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_beat: got addr=%0d beat=%0d phase=%0d, required no burst",
                         rom_addr, beat, rom_phase);
            end else begin
                exp_v = exp_q.pop_front();
                if ({rom_addr, beat, rom_phase} !== exp_v) begin
                    $display("FAIL sb_beat: got addr=%0d beat=%0d phase=%0d, required addr=%0d beat=%0d phase=%0d",
                             rom_addr, beat, rom_phase, exp_v[W+5:6], exp_v[5:2], exp_v[1:0]);
                end else begin
                    pass_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input int n);
        for (int g = 0; g < n; g++) begin
            for (int b = 0; b < 16; b++) begin
                exp_q.push_back({W'(g), 4'(b), exp_phase(b)});
            end
        end
    endtask

    // Returns one cycle after the accepting edge (cycle 1 of the job).
    task automatic accept_start(input int n);
        grp_num = W'(n);
        start = 1'b1;
        push_job(n);
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output int cyc, output int en_cnt,
                               output int first_en, output int last_en);
        cyc = 1;
        en_cnt = 0;
        first_en = -1;
        last_en = -1;
        forever begin
            if (horizontal_en === 1'b1) begin
                en_cnt++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (done === 1'b1 || cyc >= budget) break;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if ({horizontal_en, beat, rom_phase, rom_addr, busy, done, err} !==
            {1'b0, 4'd0, 2'd3, {W{1'b0}}, 3'b000}) begin
            $display("FAIL reset_outputs: got en=%b beat=%0d phase=%0d addr=%0d busy=%b done=%b err=%b, required 0/0/3/0/0/0/0",
                     horizontal_en, beat, rom_phase, rom_addr, busy, done, err);
        end else pass_cnt++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int cyc, en_cnt, first_en, last_en;
        mul_valid = 1'b1;
        accept_start(1);
        total_cnt++;
        if ({busy, horizontal_en} !== 2'b10) begin
            $display("FAIL single_wait: got busy=%b en=%b, required busy=1 en=0", busy, horizontal_en);
        end else pass_cnt++;
        run_to_done(40, cyc, en_cnt, first_en, last_en);
        total_cnt++;
        if (first_en !== 2) $display("FAIL single_first_en: got cycle %0d, required 2", first_en);
        else pass_cnt++;
        total_cnt++;
        if (en_cnt !== 16) $display("FAIL single_en_count: got %0d, required 16", en_cnt);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1 || cyc !== 18)
            $display("FAIL single_done_cycle: got done=%b at cycle %0d, required done=1 at 18", done, cyc);
        else pass_cnt++;
        total_cnt++;
        if ({busy, err, horizontal_en} !== 3'b000)
            $display("FAIL single_done_status: got busy=%b err=%b en=%b, required 0/0/0", busy, err, horizontal_en);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL single_done_pulse: got done=%b, required 0", done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc, en_cnt, first_en, last_en;
        mul_valid = 1'b1;
        accept_start(3);
        run_to_done(100, cyc, en_cnt, first_en, last_en);
        total_cnt++;
        if (en_cnt !== 48 || (last_en - first_en + 1) !== 48)
            $display("FAIL b2b_contiguous: got %0d en cycles over span %0d, required 48 over 48",
                     en_cnt, last_en - first_en + 1);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1 || cyc !== 50)
            $display("FAIL b2b_done_cycle: got done=%b at cycle %0d, required done=1 at 50", done, cyc);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0 || exp_q.size() !== 0)
            $display("FAIL b2b_single_done: got done=%b queue=%0d, required 0/0", done, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_wait_gap();
        int cyc, en_cnt, gap;
        cyc = 1;
        en_cnt = 0;
        gap = 0;
        mul_valid = 1'b1;
        accept_start(2);
        while (done !== 1'b1 && cyc < 80) begin
            if (horizontal_en === 1'b1) begin
                en_cnt++;
                if (en_cnt == 16) mul_valid = 1'b0;
            end else if (en_cnt == 16) begin
                gap++;
                if (gap == 5) mul_valid = 1'b1;
            end
            tick();
            cyc++;
        end
        total_cnt++;
        if (gap !== 5) $display("FAIL gap_length: got %0d, required 5", gap);
        else pass_cnt++;
        total_cnt++;
        if (en_cnt !== 32) $display("FAIL gap_en_count: got %0d, required 32", en_cnt);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1 || cyc !== 39 || err !== 1'b0)
            $display("FAIL gap_done: got done=%b cycle=%0d err=%b, required 1/39/0", done, cyc, err);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_underrun();
        int cyc, en_cnt, first_en, last_en;
        cyc = 1;
        en_cnt = 0;
        mul_valid = 1'b1;
        accept_start(1);
        while (done !== 1'b1 && cyc < 40) begin
            if (horizontal_en === 1'b1) begin
                en_cnt++;
                if (beat == 4'd7) mul_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        total_cnt++;
        if (en_cnt !== 16 || done !== 1'b1)
            $display("FAIL underrun_burst: got %0d en cycles done=%b, required 16/1", en_cnt, done);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b1) $display("FAIL underrun_err: got %b, required 1", err);
        else pass_cnt++;
        mul_valid = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if (err !== 1'b1) $display("FAIL underrun_sticky: got %b, required 1", err);
        else pass_cnt++;
        accept_start(1);
        total_cnt++;
        if (err !== 1'b0) $display("FAIL underrun_clear: got %b, required 0", err);
        else pass_cnt++;
        run_to_done(40, cyc, en_cnt, first_en, last_en);
        total_cnt++;
        if (en_cnt !== 16 || err !== 1'b0 || done !== 1'b1)
            $display("FAIL underrun_rerun: got en=%0d err=%b done=%b, required 16/0/1", en_cnt, err, done);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_zero_and_restart();
        int cyc, idle_en;
        accept_start(0);
        total_cnt++;
        if ({done, busy, horizontal_en} !== 3'b100)
            $display("FAIL zero_done: got done=%b busy=%b en=%b, required 1/0/0", done, busy, horizontal_en);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b, required 0", done);
        else pass_cnt++;
        mul_valid = 1'b1;
        accept_start(2);
        cyc = 1;
        while (done !== 1'b1 && cyc < 80) begin
            tick();
            cyc++;
            if (cyc == 6) begin
                grp_num = W'(5);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        total_cnt++;
        if (done !== 1'b1 || cyc !== 34 || exp_q.size() !== 0)
            $display("FAIL restart_ignored: got done=%b cycle=%0d queue=%0d, required 1/34/0",
                     done, cyc, exp_q.size());
        else pass_cnt++;
        idle_en = 0;
        repeat (20) begin
            tick();
            if (horizontal_en !== 1'b0 || busy !== 1'b0) idle_en++;
        end
        total_cnt++;
        if (idle_en !== 0) $display("FAIL restart_idle: got %0d active cycles, required 0", idle_en);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int cyc, en_cnt, first_en, last_en, found, done_cnt;
        found = 0;
        done_cnt = 0;
        mul_valid = 1'b1;
        accept_start(3);
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (horizontal_en === 1'b1 && beat == 4'd9) found = 1;
            else tick();
        end
        total_cnt++;
        if (found !== 1) $display("FAIL rstmid_reach_beat9: got %0d, required 1", found);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        total_cnt++;
        if ({horizontal_en, beat, rom_phase, rom_addr, busy, done, err} !==
            {1'b0, 4'd0, 2'd3, {W{1'b0}}, 3'b000}) begin
            $display("FAIL rstmid_async: got en=%b beat=%0d phase=%0d addr=%0d busy=%b done=%b err=%b, required 0/0/3/0/0/0/0",
                     horizontal_en, beat, rom_phase, rom_addr, busy, done, err);
        end else pass_cnt++;
        repeat (3) begin
            tick();
            if (done !== 1'b0) done_cnt++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) done_cnt++;
        end
        total_cnt++;
        if (done_cnt !== 0) $display("FAIL rstmid_no_done: got %0d, required 0", done_cnt);
        else pass_cnt++;
        accept_start(1);
        run_to_done(40, cyc, en_cnt, first_en, last_en);
        total_cnt++;
        if (en_cnt !== 16 || done !== 1'b1 || cyc !== 18)
            $display("FAIL rstmid_new_job: got en=%0d done=%b cycle=%0d, required 16/1/18", en_cnt, done, cyc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_max_job();
        int cyc, en_cnt, first_en, last_en;
        mul_valid = 1'b1;
        accept_start(15);
        run_to_done(400, cyc, en_cnt, first_en, last_en);
        total_cnt++;
        if (en_cnt !== 240 || (last_en - first_en + 1) !== 240)
            $display("FAIL max_job_bursts: got %0d en cycles over span %0d, required 240 over 240",
                     en_cnt, last_en - first_en + 1);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1 || exp_q.size() !== 0)
            $display("FAIL max_job_done: got done=%b queue=%0d, required 1/0", done, exp_q.size());
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wait_gap();
        test_underrun();
        test_zero_and_restart();
        test_reset_mid();
        test_max_job();
        repeat (2) tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
